// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential multiplier.
// State encoding, default widths and magnitude helper.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    localparam int DEF_WIDTH = 4;
    localparam int PROD_W    = 2 * DEF_WIDTH;
    localparam int MAX_W     = 64;

    // Magnitude of a sign-extended operand; callers keep the low WIDTH bits.
    function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] v);
        return v[MAX_W-1] ? (-v) : v;
    endfunction

endpackage

// File: rtl/mul_pp_row.sv
// One shifted partial-product row of the shift-add multiplier.
// Row = (multiplicand AND bit) << index, zero-extended to 2*WIDTH.
module mul_pp_row #(
    parameter int WIDTH = 4,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]   mcand,
    input  logic               bit_i,
    input  logic [IDXW-1:0]    idx,
    output logic [2*WIDTH-1:0] row
);

    logic [WIDTH-1:0] gated;

    // Gate the multiplicand by the current multiplier bit and align it.
    always_comb begin
        gated = mcand & {WIDTH{bit_i}};
        row   = (2*WIDTH)'(gated) << idx;
    end

endmodule

// File: rtl/seq_mul_unit.sv
// Sequential shift-add multiplier with signed mode and early exit.
// One partial-product row is accumulated per BUSY cycle.
module seq_mul_unit
    import mul_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int EARLY_EXIT = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product
);

    localparam int PW   = 2 * WIDTH;
    localparam int IDXW = $clog2(WIDTH);

    mul_state_e state;
    mul_state_e nstate;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic             neg;
    logic [IDXW-1:0]  idx;
    logic [PW-1:0]    acc;

    logic [PW-1:0]    row;
    logic [PW-1:0]    sum;
    logic             cur_bit;
    logic             rest_zero;
    logic             last;
    logic             accept;

    logic [MAX_W-1:0] a_ext;
    logic [MAX_W-1:0] b_ext;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    // Operand magnitudes: sign-extend only in signed mode.
    always_comb begin
        a_ext = {{(MAX_W-WIDTH){in_signed & in_a[WIDTH-1]}}, in_a};
        b_ext = {{(MAX_W-WIDTH){in_signed & in_b[WIDTH-1]}}, in_b};
        a_mag = WIDTH'(abs_val(a_ext));
        b_mag = WIDTH'(abs_val(b_ext));
    end

    mul_pp_row #(
        .WIDTH (WIDTH),
        .IDXW  (IDXW)
    ) u_row (
        .mcand (mcand),
        .bit_i (cur_bit),
        .idx   (idx),
        .row   (row)
    );

    // Current bit, running sum and final-step detection.
    always_comb begin
        cur_bit   = mplier[idx];
        sum       = acc + row;
        rest_zero = ((mplier >> idx) >> 1) == '0;
        last      = (idx == IDXW'(WIDTH-1)) ||
                    ((EARLY_EXIT != 0) && rest_zero);
        accept    = in_valid && in_ready;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nstate;
    end

    // Next-state logic; flush overrides accept and completion.
    always_comb begin
        nstate = state;
        if (flush) begin
            nstate = IDLE;
        end else begin
            unique case (state)
                IDLE: if (in_valid) nstate = BUSY;
                BUSY: if (last) nstate = DONE;
                DONE: begin
                    if (out_ready) nstate = in_valid ? BUSY : IDLE;
                end
                default: nstate = IDLE;
            endcase
        end
    end

    // Handshake outputs.
    always_comb begin
        out_valid = (state == DONE);
        in_ready  = !flush &&
                    ((state == IDLE) || ((state == DONE) && out_ready));
    end

    // Operand latch, accumulation and product load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand       <= '0;
            mplier      <= '0;
            neg         <= 1'b0;
            idx         <= '0;
            acc         <= '0;
            out_product <= '0;
        end else if (accept) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            neg    <= in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
            acc    <= '0;
            idx    <= '0;
        end else if ((state == BUSY) && !flush) begin
            acc <= sum;
            idx <= idx + IDXW'(1);
            if (last) out_product <= neg ? (-sum) : sum;
        end
    end

endmodule

// File: tb/tb_seq_mul_unit.sv
// Randomised and directed bench for seq_mul_unit.
// Three instances: W4 fixed, W4 early-exit, W8 fixed.
module tb_seq_mul_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        in_signed;
    logic        flush;
    logic        out_ready;
    int          sel;

    logic        ir0, ir1, ir2;
    logic        ov0, ov1, ov2;
    logic [7:0]  p0, p1;
    logic [15:0] p2;

    logic        rdy;
    logic        ov;
    logic [15:0] prod;

    int vecs;
    int errs;

    seq_mul_unit #(.WIDTH(4), .EARLY_EXIT(0)) dut0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid && sel == 0),
        .in_ready    (ir0),
        .in_a        (in_a[3:0]),
        .in_b        (in_b[3:0]),
        .in_signed   (in_signed),
        .flush       (flush),
        .out_valid   (ov0),
        .out_ready   (out_ready),
        .out_product (p0)
    );

    seq_mul_unit #(.WIDTH(4), .EARLY_EXIT(1)) dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid && sel == 1),
        .in_ready    (ir1),
        .in_a        (in_a[3:0]),
        .in_b        (in_b[3:0]),
        .in_signed   (in_signed),
        .flush       (flush),
        .out_valid   (ov1),
        .out_ready   (out_ready),
        .out_product (p1)
    );

    seq_mul_unit #(.WIDTH(8), .EARLY_EXIT(0)) dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid && sel == 2),
        .in_ready    (ir2),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_signed   (in_signed),
        .flush       (flush),
        .out_valid   (ov2),
        .out_ready   (out_ready),
        .out_product (p2)
    );

    always_comb begin
        rdy  = ir0;
        ov   = ov0;
        prod = {8'h00, p0};
        if (sel == 1) begin
            rdy  = ir1;
            ov   = ov1;
            prod = {8'h00, p1};
        end else if (sel == 2) begin
            rdy  = ir2;
            ov   = ov2;
            prod = p2;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (sel %0d)",
                     tag, got, exp, sel);
        end
    endtask

    // Reference: plain integer product and latency from the multiplier's
    // highest set magnitude bit.
    function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                  input logic s, output logic [15:0] p,
                                  output int lat);
        int     w;
        bit     ee;
        longint av, bv, pr, mb;
        w  = (sel == 2) ? 8 : 4;
        ee = (sel == 1);
        av = longint'(a) & ((64'sd1 << w) - 1);
        bv = longint'(b) & ((64'sd1 << w) - 1);
        if (s) begin
            if (av >= (64'sd1 << (w-1))) av = av - (64'sd1 << w);
            if (bv >= (64'sd1 << (w-1))) bv = bv - (64'sd1 << w);
        end
        pr  = av * bv;
        p   = 16'(pr & ((64'sd1 << (2*w)) - 1));
        mb  = (bv < 0) ? -bv : bv;
        lat = w;
        if (ee) begin
            lat = 1;
            for (int i = 0; i < w; i++)
                if (mb[i]) lat = i + 1;
        end
    endfunction

    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic s);
        logic [15:0] ep;
        int          el;
        int          n;
        model(a, b, s, ep, el);
        in_a      = a;
        in_b      = b;
        in_signed = s;
        in_valid  = 1'b1;
        #1;
        n = 0;
        while (!rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept", rdy, 1);
        @(negedge clk);
        in_valid  = 1'b0;
        in_a      = 8'($urandom);
        in_b      = 8'($urandom);
        in_signed = 1'($urandom);
        n = 0;
        while (!ov && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, el);
        check("product", prod, ep);
        if (out_ready) begin
            @(negedge clk);
            check("pulse", ov, 0);
        end
    endtask

    initial begin
        logic [15:0] ep;
        int          el;
        int          n;
        vecs      = 0;
        errs      = 0;
        sel       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_signed = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ov", ov, 0);
        check("rst_prod", prod, 0);
        rst_n = 1'b1;
        #1;
        check("rst_rdy", rdy, 1);

        // Directed, W4 fixed latency
        sel = 0;
        run_op(8'd15, 8'd15, 1'b0);
        run_op(8'h8, 8'h8, 1'b1);
        run_op(8'hD, 8'd5, 1'b1);
        run_op(8'd0, 8'h9, 1'b1);
        run_op(8'd8, 8'd8, 1'b0);

        // Directed, W4 early exit
        sel = 1;
        run_op(8'd7, 8'd1, 1'b0);
        run_op(8'd7, 8'd0, 1'b0);
        run_op(8'd3, 8'd9, 1'b0);

        // Backpressure then back-to-back
        sel = 0;
        out_ready = 1'b0;
        run_op(8'd9, 8'd7, 1'b0);
        model(8'd9, 8'd7, 1'b0, ep, el);
        repeat (3) begin
            @(negedge clk);
            check("hold_ov", ov, 1);
            check("hold_prod", prod, ep);
            check("hold_rdy", rdy, 0);
        end
        in_a      = 8'd2;
        in_b      = 8'd3;
        in_signed = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check("b2b_rdy", rdy, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_consumed", ov, 0);
        n = 0;
        while (!ov && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("b2b_latency", n, 4);
        check("b2b_product", prod, 16'h0006);
        @(negedge clk);

        // Flush on the second BUSY cycle
        in_a     = 8'd7;
        in_b     = 8'd6;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush_rdy", rdy, 0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_ov", ov, 0);
        check("flush_idle", rdy, 1);
        repeat (6) begin
            @(negedge clk);
            check("flush_quiet", ov, 0);
        end
        run_op(8'd5, 8'd5, 1'b0);

        // Directed, W8
        sel = 2;
        run_op(8'd255, 8'd255, 1'b0);
        run_op(8'h80, 8'h80, 1'b1);
        run_op(8'h80, 8'd127, 1'b1);

        // Asynchronous reset mid-BUSY
        in_a      = 8'd200;
        in_b      = 8'd3;
        in_signed = 1'b0;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_ov", ov, 0);
        check("arst_prod", prod, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("arst_rdy", rdy, 1);
        run_op(8'd3, 8'd4, 1'b0);

        // Randomised operands on every instance
        for (int k = 0; k < 3; k++) begin
            sel = k;
            for (int j = 0; j < 40; j++)
                run_op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
